// File: rtl/sequence_framer_0110_pkg.sv
// Shared definitions for the 0110 framer and its matching detector:
// FSM state encoding and the default sync header.
package sequence_framer_0110_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_PARITY
  } state_t;

  localparam int DEF_SYNC_W = 4;
  localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PAT = 4'b0110;

  // Index width able to count 0..n-1.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/framer_shift_reg.sv
// Loadable MSB-first parallel-to-serial shifter with a bit index and last-bit flag.
// Load takes priority over shift; zeros fill from the right so an emptied register reads 0.
module framer_shift_reg
  import sequence_framer_0110_pkg::*;
#(
  parameter int W  = 13,
  parameter int CW = idx_w(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          shift,
  input  logic [W-1:0]  load_dat,
  output logic          msb,
  output logic [CW-1:0] idx,
  output logic          last
);

  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load) begin
      sr_d  = load_dat;
      idx_d = '0;
    end else if (shift) begin
      sr_d  = {sr_q[W-2:0], 1'b0};
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign msb  = sr_q[W-1];
  assign idx  = idx_q;
  assign last = (idx_q == LAST_IDX);

endmodule

// File: rtl/sequence_framer_0110.sv
// Serial framer: sync header, MSB-first payload, even parity bit, with a
// one-word holding buffer so frames run back-to-back without gaps.
module sequence_framer_0110
  import sequence_framer_0110_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_done,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int FRAME_W = SYNC_W + DATA_W + 1;
  localparam int CW      = idx_w(FRAME_W);
  localparam logic [CW-1:0] SYNC_END = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_END = CW'(SYNC_W + DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              in_ready_q, in_ready_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              accept;
  logic              sr_load, sr_shift, sr_msb, sr_last;
  logic [CW-1:0]     sr_idx;
  logic [FRAME_W-1:0] frame_word;

  assign frame_word = {SYNC_PAT, buf_q, ^buf_q};

  framer_shift_reg #(.W(FRAME_W), .CW(CW)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (sr_load),
    .shift    (sr_shift),
    .load_dat (frame_word),
    .msb      (sr_msb),
    .idx      (sr_idx),
    .last     (sr_last)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    frame_cnt_d = frame_cnt_q;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    accept      = in_valid & in_ready_q;

    case (state_q)
      ST_IDLE: begin
        if (buf_full_q) begin
          sr_load = 1'b1;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        sr_shift = 1'b1;
        if (sr_idx == SYNC_END) state_d = ST_DATA;
      end
      ST_DATA: begin
        sr_shift = 1'b1;
        if (sr_idx == DATA_END) state_d = ST_PARITY;
      end
      ST_PARITY: begin
        if (sr_last) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          // Reloading straight from PARITY keeps dout_valid continuous.
          if (buf_full_q) begin
            sr_load = 1'b1;
            state_d = ST_SYNC;
          end else begin
            sr_shift = 1'b1;
            state_d  = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sr_load) buf_full_d = 1'b0;
    if (accept) begin
      buf_d      = in_data;
      buf_full_d = 1'b1;
    end

    in_ready_d   = ~buf_full_d;
    dout_valid_d = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_PARITY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      buf_q        <= '0;
      buf_full_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      in_ready_q   <= in_ready_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign dout       = sr_msb;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != ST_IDLE) | buf_full_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sequence_framer_0110.sv
// Bench for sequence_framer_0110: frame bits queued at acceptance and
// compared as they leave dout, plus directed reset/latency/wrap checks.
module tb_sequence_framer_0110;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, dout, dout_valid, frame_done, busy;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  sequence_framer_0110 #(.DATA_W(8), .SYNC_W(4), .SYNC_PAT(4'b0110)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard entries: {expected dout, expected frame_done}.
  logic [1:0]  sb[$];
  logic [7:0]  exp_cnt = '0;
  logic [1:0]  mon_e;
  bit          mon_has;
  logic [31:0] cap = '0;
  int          run_len = 0;
  int          last_run = 0;
  logic [3:0]  det_win = 4'hF;
  int          det_cnt = 0;
  int          ready_low = 0;

  function automatic logic [12:0] make_frame(input logic [7:0] w);
    return {4'b0110, w, ^w};
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      exp_cnt = '0;
      run_len = 0;
      det_win = 4'hF;
    end else begin
      mon_has = 1'b0;
      mon_e   = 2'b00;
      if (dout_valid) begin
        if (sb.size() == 0) begin
          check("extra_bit", {31'd0, dout_valid}, 32'd0);
        end else begin
          mon_e   = sb.pop_front();
          mon_has = 1'b1;
          check("dout", {31'd0, dout}, {31'd0, mon_e[1]});
        end
        cap     = {cap[30:0], dout};
        run_len = run_len + 1;
        det_win = {det_win[2:0], dout};
        if (det_win == 4'b0110) det_cnt++;
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        det_win = 4'hF;
      end
      check("frame_done", {31'd0, frame_done}, {31'd0, mon_has & mon_e[0]});
      check("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
      if (mon_has && mon_e[0]) exp_cnt = exp_cnt + 8'd1;
      if (in_valid && !in_ready) ready_low++;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [7:0] w);
    logic [12:0] f;
    bit ok;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (in_ready) begin
        f = make_frame(w);
        for (int b = 12; b >= 0; b--) sb.push_back({f[b], (b == 0)});
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (!busy && !dout_valid) break;
      @(negedge clk);
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int base;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    reset = 1'b0;
    check("in_ready_before_edge", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("in_ready_after_edge", {31'd0, in_ready}, 32'd1);

    // Single word 0xA5 with latency check
    send_word(8'hA5);
    check("lat_gap_valid", {31'd0, dout_valid}, 32'd0);
    check("lat_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("lat_first_valid", {31'd0, dout_valid}, 32'd1);
    wait_idle(100);
    check("a5_frame", cap & 32'h1FFF, {19'd0, 13'b0110101001010});
    check("a5_run", last_run, 32'd13);
    check("a5_cnt", {24'd0, frame_cnt}, 32'd1);
    check("a5_idle_valid", {31'd0, dout_valid}, 32'd0);

    // Back-to-back 0x01, 0x80
    do_reset();
    send_word(8'h01);
    send_word(8'h80);
    wait_idle(100);
    check("b2b_run", last_run, 32'd26);
    check("b2b_bits", cap & 32'h03FF_FFFF, {6'd0, 13'b0110000000011, 13'b0110100000001});
    check("b2b_cnt", {24'd0, frame_cnt}, 32'd2);

    // Streaming with in_valid held high
    base = ready_low;
    for (int k = 0; k < 6; k++) send_word(8'h11 * (k + 1));
    wait_idle(100);
    check("stream_ready_dropped", {31'd0, ready_low > base}, 32'd1);
    check("stream_drained", sb.size(), 32'd0);
    check("stream_cnt", {24'd0, frame_cnt}, 32'd8);

    // Detector loopback on 0x00/0xFF payloads
    base = det_cnt;
    send_word(8'h00);
    send_word(8'hFF);
    send_word(8'h00);
    send_word(8'hFF);
    wait_idle(100);
    check("det_count", det_cnt - base, 32'd4);
    check("det_frame_cnt", {24'd0, frame_cnt}, 32'd12);

    // Reset mid-frame with a word buffered
    do_reset();
    send_word(8'h3C);
    send_word(8'hC3);
    repeat (4) @(negedge clk);
    check("pre_reset_valid", {31'd0, dout_valid}, 32'd1);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("abort_dout", {31'd0, dout}, 32'd0);
    check("abort_frame_done", {31'd0, frame_done}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_abort_cnt", {24'd0, frame_cnt}, 32'd0);
    check("post_abort_busy", {31'd0, busy}, 32'd0);

    // frame_cnt wrap over 257 frames
    do_reset();
    for (int k = 0; k < 255; k++) send_word(8'(k));
    wait_idle(100);
    check("wrap_255", {24'd0, frame_cnt}, 32'd255);
    send_word(8'h5A);
    wait_idle(100);
    check("wrap_0", {24'd0, frame_cnt}, 32'd0);
    send_word(8'hC6);
    wait_idle(100);
    check("wrap_1", {24'd0, frame_cnt}, 32'd1);
    check("final_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
